// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receiver: FSM encoding, frame constants and
// prefix codes.
package ps2_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  // Odd parity: data ones plus the parity bit must be an odd count.
  function automatic logic parity_ok(input logic [7:0] data, input logic p);
    return ^{data, p};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a deglitcher: the filtered line only moves
// after FILTER_LEN consecutive synchronized samples disagree with it.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic filt_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          sync1_q, sync2_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver with a one-entry valid/ready output register.
// Optional `PS2_BREAK_EN folds E0/F0 prefixes into rx_ext/rx_break flags.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int CNT_W          = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_break,
  output logic       rx_ext,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun
);

  logic filt_clk, filt_dat, filt_clk_q, fall;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk(clk), .rst_n(rst_n), .line_i(ps2_clk), .filt_o(filt_clk)
  );
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
    .clk(clk), .rst_n(rst_n), .line_i(ps2_dat), .filt_o(filt_dat)
  );

  assign fall = filt_clk_q & ~filt_clk;

  state_e             state_q, state_d;
  logic [2:0]         bitcnt_q, bitcnt_d;
  logic [7:0]         shreg_q, shreg_d;
  logic               par_q, par_d;
  logic [CNT_W-1:0]   tmo_q, tmo_d;
  logic               good, perr, ferr;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    tmo_d    = (state_q == IDLE || fall) ? '0 : tmo_q + 1'b1;
    good     = 1'b0;
    perr     = 1'b0;
    ferr     = 1'b0;
    if (state_q != IDLE && tmo_q == CNT_W'(TIMEOUT_CYCLES)) begin
      state_d = IDLE;
      tmo_d   = '0;
      ferr    = 1'b1;
    end else if (fall) begin
      unique case (state_q)
        IDLE: if (!filt_dat) begin
          state_d  = DATA;
          bitcnt_d = '0;
        end
        DATA: begin
          shreg_d  = {filt_dat, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == 3'(DATA_BITS - 1)) state_d = PARITY;
        end
        PARITY: begin
          par_d   = filt_dat;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          // A bad stop bit outranks a parity failure.
          if (!filt_dat)                      ferr = 1'b1;
          else if (!parity_ok(shreg_q, par_q)) perr = 1'b1;
          else                                good = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_clk_q <= 1'b1;
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
    end else begin
      filt_clk_q <= filt_clk;
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
    end
  end

  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       ovr_q, ovr_d;
  logic       perr_q, ferr_q;
  logic       present, load;

`ifdef PS2_BREAK_EN
  logic ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
  logic rx_ext_q, rx_ext_d, rx_break_q, rx_break_d;
  assign present = good && shreg_q != PS2_EXT && shreg_q != PS2_BRK;
`else
  assign present = good;
`endif

  // Same-cycle transfer frees the slot, so the new byte loads without overrun.
  assign load = present && !(rx_valid_q && !rx_ready);

  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q && !rx_ready;
    ovr_d      = present && !load;
    if (load) begin
      rx_data_d  = shreg_q;
      rx_valid_d = 1'b1;
    end
  end

`ifdef PS2_BREAK_EN
  always_comb begin
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    rx_ext_d   = rx_ext_q;
    rx_break_d = rx_break_q;
    if (perr || ferr) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end else if (good && shreg_q == PS2_EXT) begin
      ext_pend_d = 1'b1;
    end else if (good && shreg_q == PS2_BRK) begin
      brk_pend_d = 1'b1;
    end else if (load) begin
      rx_ext_d   = ext_pend_q;
      rx_break_d = brk_pend_q;
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      rx_ext_q   <= 1'b0;
      rx_break_q <= 1'b0;
    end else begin
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
      rx_ext_q   <= rx_ext_d;
      rx_break_q <= rx_break_d;
    end
  end

  assign rx_ext   = rx_ext_q;
  assign rx_break = rx_break_q;
`else
  assign rx_ext   = 1'b0;
  assign rx_break = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ovr_q      <= ovr_d;
      perr_q     <= perr;
      ferr_q     <= ferr;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign overrun    = ovr_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: a frame-level model predicts presented bytes and
// error/overrun pulses; a per-cycle monitor compares the DUT against it.
module tb_ps2_rx;
  import ps2_pkg::*;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 5000;
  localparam int CNT_W          = 13;
  localparam int HALF           = 40;
`ifdef PS2_BREAK_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_break, rx_ext, parity_err, frame_err, overrun;

  ps2_rx #(
    .FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_break(rx_break), .rx_ext(rx_ext), .parity_err(parity_err),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // ---------------- frame-level model ----------------
  typedef struct {
    logic [7:0] data;
    logic       ext;
    logic       brk;
  } exp_t;

  exp_t exp_q[$];
  int   exp_perr = 0, exp_ferr = 0, exp_ovr = 0;
  bit   model_full = 1'b0, ext_pend = 1'b0, brk_pend = 1'b0;

  task automatic model_frame(input logic [7:0] d, input logic p, input logic stop);
    if (!stop) begin
      exp_ferr++; ext_pend = 1'b0; brk_pend = 1'b0;
    end else if ((($countones(d) + int'(p)) % 2) == 0) begin
      exp_perr++; ext_pend = 1'b0; brk_pend = 1'b0;
    end else if (BRK_EN && d == 8'hE0) begin
      ext_pend = 1'b1;
    end else if (BRK_EN && d == 8'hF0) begin
      brk_pend = 1'b1;
    end else if (model_full) begin
      exp_ovr++;
    end else begin
      exp_q.push_back('{data: d, ext: ext_pend, brk: brk_pend});
      ext_pend   = 1'b0;
      brk_pend   = 1'b0;
      model_full = !rx_ready;
    end
  endtask

  // ---------------- monitor ----------------
  int         cyc = 0, ferr_cyc = 0, last_fall_cyc = 0;
  int         obs_perr = 0, obs_ferr = 0, obs_ovr = 0, obs_loads = 0, valid_cycles = 0;
  logic [7:0] cur_data = '0, last_data = '0;
  logic       last_ext = 1'b0, last_brk = 1'b0;
  logic       prev_valid = 1'b0, prev_ready = 1'b0;
  logic       prev_perr = 1'b0, prev_ferr = 1'b0, prev_ovr = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0; prev_ready = 1'b0;
      prev_perr = 1'b0; prev_ferr = 1'b0; prev_ovr = 1'b0;
    end else begin
      cyc++;
      if (parity_err) begin obs_perr++; check("perr_one_cycle", prev_perr, 0); end
      if (frame_err)  begin obs_ferr++; ferr_cyc = cyc; check("ferr_one_cycle", prev_ferr, 0); end
      if (overrun)    begin obs_ovr++;  check("ovr_one_cycle", prev_ovr, 0); end
      if (rx_valid) valid_cycles++;
      if (rx_valid && (!prev_valid || prev_ready)) begin
        obs_loads++;
        last_data = rx_data; last_ext = rx_ext; last_brk = rx_break;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_load: got byte %0h, expected no byte", rx_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rx_data", rx_data, e.data);
          check("rx_ext", rx_ext, e.ext);
          check("rx_break", rx_break, e.brk);
          check("no_pulse_on_load", {parity_err, frame_err, overrun}, 3'b000);
          cur_data = e.data;
        end
      end else if (rx_valid) begin
        check("rx_data_held", rx_data, cur_data);
      end
      prev_valid = rx_valid; prev_ready = rx_ready;
      prev_perr = parity_err; prev_ferr = frame_err; prev_ovr = overrun;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    ps2_dat = b;
    tick(HALF / 2);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    tick(HALF);
    ps2_clk = 1'b1;
    if (glitch) begin
      tick(5); ps2_clk = 1'b0; tick(3); ps2_clk = 1'b1; tick(HALF / 2 - 8);
    end else begin
      tick(HALF / 2);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop, input int glitch_bit);
    logic [FRAME_BITS-1:0] bits;
    model_frame(d, p, stop);
    bits = {stop, p, d, 1'b0};
    for (int i = 0; i < FRAME_BITS; i++) send_bit(bits[i], i == glitch_bit);
    ps2_dat = 1'b1;
    tick(30);
  endtask

  initial begin
    int lat;
    tick(5);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_errs", {parity_err, frame_err, overrun, rx_ext, rx_break}, 0);
    rst_n = 1'b1;
    tick(20);

    // Clean byte, consumer ready.
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    check("t1_loads", obs_loads, 1);
    check("t1_byte", last_data, 8'h1C);
    check("t1_valid_cycles", valid_cycles, 1);
    check("t1_no_errs", obs_perr + obs_ferr + obs_ovr, 0);

    // Parity error.
    send_frame(8'h1C, 1'b1, 1'b1, -1);
    check("t2_perr", obs_perr, 1);
    check("t2_loads", obs_loads, 1);

    // Stop bit error with good parity.
    send_frame(8'h5A, 1'b1, 1'b0, -1);
    check("t3_ferr", obs_ferr, 1);
    check("t3_perr", obs_perr, 1);

    // Timeout mid-frame: start + 3 data bits, then silence.
    send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    ps2_dat = 1'b1;
    exp_ferr++;
    tick(6000);
    check("t4_ferr", obs_ferr, 2);
    lat = ferr_cyc - last_fall_cyc;
    check("t4_timeout_window", (lat >= TIMEOUT_CYCLES && lat <= TIMEOUT_CYCLES + 20), 1);
    send_frame(8'h5A, 1'b1, 1'b1, -1);
    check("t4_byte", last_data, 8'h5A);
    check("t4_loads", obs_loads, 2);

    // Overrun: consumer stalled.
    rx_ready = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    send_frame(8'h32, 1'b0, 1'b1, -1);
    check("t5_held_valid", rx_valid, 1);
    check("t5_held_byte", rx_data, 8'h1C);
    check("t5_ovr", obs_ovr, 1);
    rx_ready = 1'b1;
    model_full = 1'b0;
    tick(5);
    check("t5_drained", rx_valid, 0);
    check("t5_loads", obs_loads, 3);

    // Short low glitch on ps2_clk during data bits.
    send_frame(8'h1C, 1'b0, 1'b1, 4);
    check("t6_byte", last_data, 8'h1C);
    check("t6_loads", obs_loads, 4);

    // Reset in the middle of a frame.
    send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    rst_n = 1'b0;
    exp_q.delete(); ext_pend = 1'b0; brk_pend = 1'b0; model_full = 1'b0;
    ps2_dat = 1'b1;
    tick(3);
    check("t7_rst_valid", rx_valid, 0);
    rst_n = 1'b1;
    tick(20);
    send_frame(8'h32, 1'b0, 1'b1, -1);
    check("t7_byte", last_data, 8'h32);
    check("t7_loads", obs_loads, 5);

    // Prefix sequence E0 F0 75, then 75.
    send_frame(8'hE0, 1'b0, 1'b1, -1);
    send_frame(8'hF0, 1'b1, 1'b1, -1);
    send_frame(8'h75, 1'b0, 1'b1, -1);
    check("t8_byte", last_data, 8'h75);
    check("t8_ext", last_ext, BRK_EN);
    check("t8_brk", last_brk, BRK_EN);
    send_frame(8'h75, 1'b0, 1'b1, -1);
    check("t8_plain_flags", {last_ext, last_brk}, 2'b00);
    check("t8_loads", obs_loads, BRK_EN ? 7 : 9);

    check("model_perr", obs_perr, exp_perr);
    check("model_ferr", obs_ferr, exp_ferr);
    check("model_ovr", obs_ovr, exp_ovr);
    check("model_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
